// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the single-port RAM arbiter: requester ids,
//   the default starvation limit and the starve-counter width.
//   Ports: none (package).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        PORT_HOST  = 2'd0,
        PORT_DATA  = 2'd1,
        PORT_FETCH = 2'd2,
        PORT_NONE  = 2'd3
    } port_id_t;

    localparam int NUM_PORTS        = 3;
    localparam int STARVE_LIMIT_DEF = 4;
    // Wide enough for the largest allowed limit (15).
    localparam int CNT_W            = 4;

    // One-hot request vector for a port id; PORT_NONE maps to all zeros.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] id);
        logic [NUM_PORTS-1:0] oh;
        case (id)
            PORT_HOST:  oh = 3'b001;
            PORT_DATA:  oh = 3'b010;
            PORT_FETCH: oh = 3'b100;
            default:    oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational winner select for the RAM arbiter.
//   Ports:
//     i_elig    [2:0]  eligible requesters, indexed by port id
//     i_starved [2:0]  requesters whose starve counter is saturated
//     o_port    [1:0]  winning port id, PORT_NONE when nothing is eligible
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_elig,
    input  logic [NUM_PORTS-1:0] i_starved,
    output logic [1:0]           o_port
);

    logic [NUM_PORTS-1:0] w_hot;

    // Starved requesters override the normal order; among themselves the
    // host goes first so a long program load cannot be locked out by the CPU.
    always_comb begin
        w_hot  = i_elig & i_starved;
        o_port = PORT_NONE;
        if (w_hot[PORT_HOST])          o_port = PORT_HOST;
        else if (w_hot[PORT_DATA])     o_port = PORT_DATA;
        else if (w_hot[PORT_FETCH])    o_port = PORT_FETCH;
        else if (i_elig[PORT_DATA])    o_port = PORT_DATA;
        else if (i_elig[PORT_FETCH])   o_port = PORT_FETCH;
        else if (i_elig[PORT_HOST])    o_port = PORT_HOST;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port RAM between the AXI host path (h_*), the CPU
//   load/store unit (d_*) and the CPU fetch unit (f_*). One request is
//   chosen per cycle, registered onto the RAM port together with a one-cycle
//   gnt pulse, and the read data is steered back with an rvalid pulse one
//   cycle after the grant.
//   Ports:
//     S_AXI_ACLK, S_AXI_ARESET     clock, synchronous active-high reset
//     host_lock                    only the host may be granted while high
//     {h,d,f}_req/_addr            requests, held until gnt
//     {h,d}_we/_wdata/_wstrb       write attributes (fetch is read-only)
//     {h,d,f}_gnt, {h,d,f}_rvalid  accept and read-data-valid pulses
//     rdata                        shared read data (pass-through of mem_rdata)
//     mem_en/_we/_addr/_wdata      registered RAM command
//     mem_rdata                    RAM read data, one cycle after mem_en
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESET,
    input  logic                host_lock,
    input  logic                h_req,
    input  logic                h_we,
    input  logic [ADDR_W-1:0]   h_addr,
    input  logic [DATA_W-1:0]   h_wdata,
    input  logic [DATA_W/8-1:0] h_wstrb,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic                f_req,
    input  logic [ADDR_W-1:0]   f_addr,
    output logic                h_gnt,
    output logic                d_gnt,
    output logic                f_gnt,
    output logic                h_rvalid,
    output logic                d_rvalid,
    output logic                f_rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int                STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0]  LIMIT  = CNT_W'(STARVE_LIMIT);

    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_elig;
    logic [NUM_PORTS-1:0] w_starved;
    logic [1:0]           w_win;
    logic                 w_any;
    logic                 w_win_we;
    logic [STRB_W-1:0]    w_win_strb;
    logic [ADDR_W-1:0]    w_win_addr;
    logic [DATA_W-1:0]    w_win_wdata;

    logic [CNT_W-1:0]     r_cnt [NUM_PORTS];

    logic                 r_vld_p1;
    logic [NUM_PORTS-1:0] r_gnt_p1;
    logic [STRB_W-1:0]    r_mem_we_p1;
    logic [ADDR_W-1:0]    r_mem_addr_p1;
    logic [DATA_W-1:0]    r_mem_wdata_p1;
    logic                 r_rd_p1;
    logic [1:0]           r_own_p1;
    logic [NUM_PORTS-1:0] r_rvalid_p2;

    assign w_req = {f_req, d_req, h_req};

    // The port whose gnt is showing this cycle still has req high for the
    // accepted command, so it is masked to avoid a double grant.
    assign w_elig = w_req & ~r_gnt_p1 & (host_lock ? 3'b001 : 3'b111);

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_starved[p] = (r_cnt[p] >= LIMIT);
        end
    end

    mem_arb_pick u_pick (
        .i_elig    (w_elig),
        .i_starved (w_starved),
        .o_port    (w_win)
    );

    assign w_any = (w_win != PORT_NONE);

    // Address and write data default to the current RAM port values so an
    // idle cycle (or a fetch, which has no write data) leaves them unchanged.
    always_comb begin
        w_win_we    = 1'b0;
        w_win_strb  = '0;
        w_win_addr  = r_mem_addr_p1;
        w_win_wdata = r_mem_wdata_p1;
        case (w_win)
            PORT_HOST: begin
                w_win_we    = h_we;
                w_win_strb  = h_wstrb;
                w_win_addr  = h_addr;
                w_win_wdata = h_wdata;
            end
            PORT_DATA: begin
                w_win_we    = d_we;
                w_win_strb  = d_wstrb;
                w_win_addr  = d_addr;
                w_win_wdata = d_wdata;
            end
            PORT_FETCH: begin
                w_win_addr  = f_addr;
            end
            default: ;
        endcase
    end

    // Starve counters: only an eligible loser counts up; masked or locked-out
    // requesters hold, and a dropped or winning request starts over.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!w_req[p] || (w_win == 2'(p))) begin
                    r_cnt[p] <= '0;
                end else if (w_elig[p] && (r_cnt[p] < LIMIT)) begin
                    r_cnt[p] <= r_cnt[p] + 1'b1;
                end
            end
        end
    end

    // ---- stage p1: RAM command and grant ----
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_vld_p1       <= 1'b0;
            r_gnt_p1       <= '0;
            r_mem_we_p1    <= '0;
            r_mem_addr_p1  <= '0;
            r_mem_wdata_p1 <= '0;
            r_rd_p1        <= 1'b0;
            r_own_p1       <= PORT_NONE;
        end else begin
            r_vld_p1       <= w_any;
            r_gnt_p1       <= port_onehot(w_win);
            r_mem_we_p1    <= w_win_we ? w_win_strb : '0;
            r_mem_addr_p1  <= w_win_addr;
            r_mem_wdata_p1 <= w_win_wdata;
            r_rd_p1        <= w_any && !w_win_we;
            r_own_p1       <= w_win;
        end
    end

    // ---- stage p2: read response steering ----
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rvalid_p2 <= '0;
        end else begin
            r_rvalid_p2 <= r_rd_p1 ? port_onehot(r_own_p1) : '0;
        end
    end

    assign mem_en    = r_vld_p1;
    assign mem_we    = r_mem_we_p1;
    assign mem_addr  = r_mem_addr_p1;
    assign mem_wdata = r_mem_wdata_p1;

    assign h_gnt     = r_gnt_p1[PORT_HOST];
    assign d_gnt     = r_gnt_p1[PORT_DATA];
    assign f_gnt     = r_gnt_p1[PORT_FETCH];

    assign h_rvalid  = r_rvalid_p2[PORT_HOST];
    assign d_rvalid  = r_rvalid_p2[PORT_DATA];
    assign f_rvalid  = r_rvalid_p2[PORT_FETCH];

    assign rdata     = mem_rdata;

endmodule
